// File: rtl/order_sequencer_pkg.sv
// Shared definitions for the order sequencer: widths, FSM state encoding and
// order-class codes.
package order_sequencer_pkg;

  localparam int ORDER_W   = 8;
  localparam int REG_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_SUBC_WAIT = 3'd3,
    ST_EXT_WAIT  = 3'd4,
    ST_WB        = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_BC   = 3'd0,
    CLS_ADD  = 3'd1,
    CLS_SUBC = 3'd2,
    CLS_EXT  = 3'd3,
    CLS_REG  = 3'd4,
    CLS_IMM  = 3'd5
  } order_class_e;

endpackage

// File: rtl/order_sequencer_if.sv
// Bus between the sequencer, program memory, the SUBC/EXT sources and the
// register file.
interface order_sequencer_if
  import order_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 8
) ();

  logic [PC_WIDTH-1:0]  pmem_addr;
  logic [ORDER_W-1:0]   pmem_data;
  logic [ORDER_W-1:0]   order;
  logic                 reg_we;
  logic [REG_IDX_W-1:0] reg_waddr;
  logic                 subc_start;
  logic                 subc_done;
  logic                 ext_req;
  logic                 ext_ack;
  logic                 busy;

  modport master (
    output pmem_addr, order, reg_we, reg_waddr, subc_start, ext_req, busy,
    input  pmem_data, subc_done, ext_ack
  );

  modport slave (
    input  pmem_addr, order, reg_we, reg_waddr, subc_start, ext_req, busy,
    output pmem_data, subc_done, ext_ack
  );

endinterface

// File: rtl/order_sequencer_class_decode.sv
// Combinational order-word classifier; maps an 8-bit order onto its class code.
module order_sequencer_class_decode
  import order_sequencer_pkg::*;
(
  input  logic [ORDER_W-1:0] order_i,
  output order_class_e       class_o
);

  // Priority-free pattern match: the patterns below are mutually exclusive.
  always_comb begin
    class_o = CLS_BC;
    casez (order_i)
      8'b11??_????: class_o = CLS_REG;
      8'b10??_????: class_o = CLS_IMM;
      8'b00??_????: class_o = CLS_BC;
      8'b010?_????: class_o = CLS_ADD;
      8'b0110_????: class_o = CLS_SUBC;
      8'b0111_0???: class_o = CLS_EXT;
      8'b0111_1???: class_o = CLS_REG;
      default:      class_o = CLS_BC;
    endcase
  end

endmodule

// File: rtl/order_sequencer.sv
// Fetch/load/writeback control FSM with the PC and ORDER registers; all bus
// outputs come straight from registers.
module order_sequencer
  import order_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_i,
  order_sequencer_if.master  bus
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [ORDER_W-1:0]   order_q, order_d;
  logic                 reg_we_q, subc_start_q, ext_req_q, busy_q;
  logic                 subc_start_d;
  order_class_e         load_class_s;

  order_sequencer_class_decode u_decode (
    .order_i (bus.pmem_data),
    .class_o (load_class_s)
  );

  // Next-state, PC and ORDER update; handshake inputs only matter in their wait states.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    order_d      = order_q;
    subc_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        order_d = bus.pmem_data;
        pc_d    = pc_q + PC_ONE;
        case (load_class_s)
          CLS_SUBC: begin
            state_d      = ST_SUBC_WAIT;
            subc_start_d = 1'b1;
          end
          CLS_EXT: state_d = ST_EXT_WAIT;
          default: state_d = ST_WB;
        endcase
      end
      ST_SUBC_WAIT: begin
        if (bus.subc_done) state_d = ST_WB;
        else               state_d = ST_SUBC_WAIT;
      end
      ST_EXT_WAIT: begin
        if (bus.ext_ack) state_d = ST_WB;
        else             state_d = ST_EXT_WAIT;
      end
      ST_WB: begin
        if (run_i) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC, ORDER and output registers; outputs are pre-decoded from state_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      order_q      <= {ORDER_W{1'b0}};
      reg_we_q     <= 1'b0;
      subc_start_q <= 1'b0;
      ext_req_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      order_q      <= order_d;
      reg_we_q     <= (state_d == ST_WB);
      subc_start_q <= subc_start_d;
      ext_req_q    <= (state_d == ST_EXT_WAIT);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign bus.pmem_addr  = pc_q;
  assign bus.order      = order_q;
  assign bus.reg_waddr  = order_q[REG_IDX_W-1:0];
  assign bus.reg_we     = reg_we_q;
  assign bus.subc_start = subc_start_q;
  assign bus.ext_req    = ext_req_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_order_sequencer.sv
// Directed bench for order_sequencer: a cycle-level order model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_order_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic run   = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [0:255];

  order_sequencer_if #(.PC_WIDTH(8)) bus ();

  order_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run_i (run),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // synchronous program memory
  always @(posedge clk) bus.pmem_data <= mem[bus.pmem_addr];

  function automatic bit is_subc(input logic [7:0] o);
    return (o >= 8'h60) && (o <= 8'h6F);
  endfunction

  function automatic bit is_ext(input logic [7:0] o);
    return (o >= 8'h70) && (o <= 8'h77);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: m_cyc counts cycles since the order began (1 fetch, 2 load, 3+ after
  // load); m_hs marks that the order's handshake (if any) is satisfied.
  int         m_cyc   = 0;
  logic       m_hs    = 1'b0;
  logic [7:0] m_pc    = 8'h00;
  logic [7:0] m_order = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0; m_hs <= 1'b0; m_pc <= 8'h00; m_order <= 8'h00;
    end else if (m_cyc == 0) begin
      if (run) m_cyc <= 1;
    end else if (m_cyc == 1) begin
      m_cyc <= 2;
    end else if (m_cyc == 2) begin
      m_order <= mem[m_pc];
      m_pc    <= m_pc + 8'd1;
      m_cyc   <= 3;
      m_hs    <= !(is_subc(mem[m_pc]) || is_ext(mem[m_pc]));
    end else if (m_hs) begin
      m_cyc <= run ? 1 : 0;
      m_hs  <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if ((is_subc(m_order) && bus.subc_done) || (is_ext(m_order) && bus.ext_ack))
        m_hs <= 1'b1;
    end
  end

  always @(negedge clk) begin
    cmp("busy",       32'(bus.busy),       32'(m_cyc != 0));
    cmp("reg_we",     32'(bus.reg_we),     32'((m_cyc >= 3) && m_hs));
    cmp("subc_start", 32'(bus.subc_start), 32'((m_cyc == 3) && is_subc(m_order)));
    cmp("ext_req",    32'(bus.ext_req),    32'((m_cyc >= 3) && !m_hs && is_ext(m_order)));
    cmp("pmem_addr",  32'(bus.pmem_addr),  32'(m_pc));
    cmp("order",      32'(bus.order),      32'(m_order));
    cmp("reg_waddr",  32'(bus.reg_waddr),  32'(m_order[1:0]));
  end

  // Runs one order; cycle 1 is the first negedge after entry (FETCH).
  task automatic run_one(input int done_at, input int early_at, input bit hold_run,
                         input int drop_at, output int lat, output int n_start,
                         output int n_req, output logic [7:0] ord, output logic [1:0] wa,
                         output logic [7:0] first_addr, output logic [7:0] wb_addr);
    lat = -1; n_start = 0; n_req = 0; ord = 8'h00; wa = 2'd0;
    first_addr = 8'h00; wb_addr = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) first_addr = bus.pmem_addr;
      if (bus.subc_start) n_start++;
      if (bus.ext_req) n_req++;
      if (bus.reg_we) begin
        lat = c; ord = bus.order; wa = bus.reg_waddr; wb_addr = bus.pmem_addr;
        run = hold_run; bus.subc_done = 1'b0; bus.ext_ack = 1'b0;
        break;
      end
      bus.subc_done = (c == done_at) || (c == early_at);
      bus.ext_ack   = (c == done_at);
      if (c == drop_at) run = 1'b0;
    end
  endtask

  int lat, ns, nr;
  logic [7:0] ord, fa, wba;
  logic [1:0] wa;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = i[7:0];
      if (is_subc(v) || is_ext(v)) v = v ^ 8'h80;
      mem[i] = v;
    end
    mem[0] = 8'h85; mem[1] = 8'h41; mem[2] = 8'h62; mem[3] = 8'h73; mem[255] = 8'h8A;
    bus.subc_done = 1'b0;
    bus.ext_ack   = 1'b0;

    repeat (2) @(negedge clk);
    cmp("rst_busy", 32'(bus.busy), 32'h0);
    cmp("rst_addr", 32'(bus.pmem_addr), 32'h0);
    cmp("rst_order", 32'(bus.order), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;

    // IMM 0x85 then ADD 0x41
    run_one(0, 0, 1'b1, 0, lat, ns, nr, ord, wa, fa, wba);
    cmp("imm_lat", 32'(lat), 32'd3);
    cmp("imm_order", 32'(ord), 32'h85);
    cmp("imm_waddr", 32'(wa), 32'd1);
    cmp("imm_first_addr", 32'(fa), 32'h00);
    cmp("imm_wb_addr", 32'(wba), 32'h01);
    run_one(0, 0, 1'b0, 0, lat, ns, nr, ord, wa, fa, wba);
    cmp("add_lat", 32'(lat), 32'd3);
    cmp("add_order", 32'(ord), 32'h41);
    cmp("add_waddr", 32'(wa), 32'd1);
    cmp("add_first_addr", 32'(fa), 32'h01);

    // SUBC 0x62: early DONE in FETCH, then low twice, high on third wait cycle
    @(negedge clk); run = 1'b1;
    run_one(5, 1, 1'b0, 0, lat, ns, nr, ord, wa, fa, wba);
    cmp("subc_lat", 32'(lat), 32'd6);
    cmp("subc_starts", 32'(ns), 32'd1);
    cmp("subc_order", 32'(ord), 32'h62);
    cmp("subc_waddr", 32'(wa), 32'd2);

    // EXT 0x73, ACK after 4 wait cycles, RUN dropped mid-wait
    @(negedge clk); run = 1'b1;
    run_one(6, 0, 1'b0, 4, lat, ns, nr, ord, wa, fa, wba);
    cmp("ext_lat", 32'(lat), 32'd7);
    cmp("ext_reqs", 32'(nr), 32'd4);
    cmp("ext_waddr", 32'(wa), 32'd3);
    cmp("ext_order", 32'(ord), 32'h73);
    repeat (3) @(negedge clk);
    cmp("idle_busy", 32'(bus.busy), 32'h0);
    cmp("idle_pc", 32'(bus.pmem_addr), 32'h04);

    // back-to-back single-cycle orders up to the wrap point
    run = 1'b1;
    for (int a = 4; a < 255; a++) begin
      run_one(0, 0, 1'b1, 0, lat, ns, nr, ord, wa, fa, wba);
      cmp("b2b_lat", 32'(lat), 32'd3);
    end
    run_one(0, 0, 1'b1, 0, lat, ns, nr, ord, wa, fa, wba);
    cmp("wrap_first_addr", 32'(fa), 32'hFF);
    cmp("wrap_order", 32'(ord), 32'h8A);
    cmp("wrap_wb_addr", 32'(wba), 32'h00);
    run_one(0, 0, 1'b1, 0, lat, ns, nr, ord, wa, fa, wba);
    cmp("post_wrap_addr", 32'(fa), 32'h00);
    cmp("post_wrap_order", 32'(ord), 32'h85);
    run_one(0, 0, 1'b1, 0, lat, ns, nr, ord, wa, fa, wba);
    cmp("post_wrap_order2", 32'(ord), 32'h41);

    // reset asserted in the first SUBC_WAIT cycle of 0x62
    repeat (3) @(negedge clk);
    cmp("pre_rst_subc_start", 32'(bus.subc_start), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_busy", 32'(bus.busy), 32'h0);
    cmp("arst_subc_start", 32'(bus.subc_start), 32'h0);
    cmp("arst_reg_we", 32'(bus.reg_we), 32'h0);
    cmp("arst_pc", 32'(bus.pmem_addr), 32'h00);
    cmp("arst_order", 32'(bus.order), 32'h00);
    cmp("arst_waddr", 32'(bus.reg_waddr), 32'h0);
    @(negedge clk);
    cmp("arst_hold_we", 32'(bus.reg_we), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(0, 0, 1'b0, 0, lat, ns, nr, ord, wa, fa, wba);
    cmp("resume_addr", 32'(fa), 32'h00);
    cmp("resume_order", 32'(ord), 32'h85);
    cmp("resume_lat", 32'(lat), 32'd3);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
